// File: rtl/seq_divider_pkg.sv
// Shared divider types and constants.
// Holds the FSM state enum, default data width and a clog2 helper.
package cpu_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        ZERO = 2'd3
    } divState_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration on unsigned magnitudes.
// Ports: remIn/quotIn/divMag in, remOut/quotOut out (all WIDTH bits).
module div_step
    import cpu_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic [WIDTH-1:0] remIn,
    input  logic [WIDTH-1:0] quotIn,
    input  logic [WIDTH-1:0] divMag,
    output logic [WIDTH-1:0] remOut,
    output logic [WIDTH-1:0] quotOut
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // Partial remainder is always below divMag, so the shifted value
    // fits in WIDTH+1 bits and trial[WIDTH] is a clean sign bit.
    assign shifted = {remIn, quotIn[WIDTH-1]};
    assign trial   = shifted - {1'b0, divMag};

    always_comb begin
        remOut  = shifted[WIDTH-1:0];
        quotOut = {quotIn[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH]) begin
            remOut  = trial[WIDTH-1:0];
            quotOut = {quotIn[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Multicycle signed restoring divider (MIPS DIV semantics).
// Ports: clk, reset, start, dividend, divisor in; busy, done,
// div_by_zero, quotient, remainder out.
module seq_divider
    import cpu_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = clog2(WIDTH) + 1;

    divState_t        state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] remMag;
    logic [WIDTH-1:0] quotMag;
    logic [WIDTH-1:0] divMag;
    logic             signQ;
    logic             signR;

    logic [WIDTH-1:0] remNext;
    logic [WIDTH-1:0] quotNext;
    logic [WIDTH-1:0] absA;
    logic [WIDTH-1:0] absB;

    // Unsigned magnitudes: |-2^(W-1)| stays exact as 0x80..0.
    assign absA = dividend[WIDTH-1] ? -dividend : dividend;
    assign absB = divisor[WIDTH-1]  ? -divisor  : divisor;

    div_step #(
        .WIDTH(WIDTH)
    ) uStep (
        .remIn  (remMag),
        .quotIn (quotMag),
        .divMag (divMag),
        .remOut (remNext),
        .quotOut(quotNext)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            count       <= '0;
            remMag      <= '0;
            quotMag     <= '0;
            divMag      <= '0;
            signQ       <= 1'b0;
            signR       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            unique case (state)
                IDLE: begin
                    // A start coincident with done is dropped.
                    if (start && !done) begin
                        busy    <= 1'b1;
                        divMag  <= absB;
                        quotMag <= absA;
                        remMag  <= '0;
                        signQ   <= dividend[WIDTH-1]
                                 ^ divisor[WIDTH-1];
                        signR   <= dividend[WIDTH-1];
                        count   <= CW'(WIDTH);
                        if (divisor == '0) begin
                            state <= ZERO;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    remMag  <= remNext;
                    quotMag <= quotNext;
                    count   <= count - CW'(1);
                    if (count == CW'(1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    quotient  <= signQ ? -quotMag : quotMag;
                    remainder <= signR ? -remMag  : remMag;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                ZERO: begin
                    done        <= 1'b1;
                    div_by_zero <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider.
// Driver pushes expected results; a negedge monitor checks each done.
module tb_seq_divider;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int checks;
    int errors;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dbz;
    } exp_t;

    exp_t sbQ[$];

    seq_divider #(
        .WIDTH(32)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero),
        .quotient   (quotient),
        .remainder  (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] q,
                        input logic [31:0] r,
                        input logic dbz);
        exp_t e;
        e.q   = q;
        e.r   = r;
        e.dbz = dbz;
        sbQ.push_back(e);
    endtask

    // Returns just after the accepting edge E0.
    task automatic issue(input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge clk);
        while (done) @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic waitDone(output int lat);
        lat = 0;
        while (lat < 100) begin
            @(posedge clk);
            #1 lat++;
            if (done) break;
        end
        if (!done) begin
            errors++;
            $display("FAIL timeout: no done after %0d cycles", lat);
        end
    endtask

    task automatic runOp(input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [31:0] q,
                         input logic [31:0] r);
        int lat;
        push(q, r, 1'b0);
        issue(a, b);
        waitDone(lat);
        check("latency", lat, 33);
    endtask

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            checks++;
            if (busy && done) begin
                errors++;
                $display("FAIL busyDone: busy=%b done=%b", busy, done);
            end
            if (done) begin
                if (sbQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpectedDone: got done, expected none");
                end else begin
                    e = sbQ.pop_front();
                    check("quotient", quotient, e.q);
                    check("remainder", remainder, e.r);
                    check("divByZero", {31'd0, div_by_zero},
                          {31'd0, e.dbz});
                end
            end
        end
    end

    initial begin
        int n;
        int lat;
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #3;
        check("rstBusy", {31'd0, busy}, 32'd0);
        check("rstDone", {31'd0, done}, 32'd0);
        check("rstQuot", quotient, 32'd0);
        check("rstRem", remainder, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        runOp(32'd100, 32'd7, 32'd14, 32'd2);
        runOp(-32'sd100, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE);
        runOp(32'd100, -32'sd7, 32'hFFFFFFF2, 32'd2);
        runOp(32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0);
        runOp(32'h80000000, 32'd1, 32'h80000000, 32'd0);
        runOp(-32'sd7, -32'sd2, 32'd3, 32'hFFFFFFFF);
        runOp(32'd7, 32'd100, 32'd0, 32'd7);

        // Divide by zero after a 100/7 preload.
        runOp(32'd100, 32'd7, 32'd14, 32'd2);
        push(32'd14, 32'd2, 1'b1);
        issue(32'd5, 32'd0);
        check("dbzBusyE0", {31'd0, busy}, 32'd1);
        check("dbzDoneE0", {31'd0, done}, 32'd0);
        @(posedge clk);
        #1;
        check("dbzDoneE1", {31'd0, done}, 32'd1);
        check("dbzFlagE1", {31'd0, div_by_zero}, 32'd1);
        check("dbzBusyE1", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        check("dbzDoneE2", {31'd0, done}, 32'd0);

        // Starts while busy and on the done cycle are ignored.
        push(32'd14, 32'd2, 1'b0);
        issue(32'd100, 32'd7);
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            #1 n++;
            if (n == 5) begin
                dividend = 32'd9;
                divisor  = 32'd3;
                start    = 1'b1;
            end
            if (n == 6) start = 1'b0;
            if (done) break;
        end
        check("repulseLat", n, 33);
        push(32'd3, 32'd0, 1'b0);
        dividend = 32'd9;
        divisor  = 32'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        check("ignoredOnDone", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1 start = 1'b0;
        check("acceptAfter", {31'd0, busy}, 32'd1);
        waitDone(lat);
        check("latency9by3", lat, 33);

        // Asynchronous reset mid-operation.
        issue(32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("asyncQuot", quotient, 32'd0);
        check("asyncRem", remainder, 32'd0);
        check("asyncBusy", {31'd0, busy}, 32'd0);
        check("asyncDone", {31'd0, done}, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        runOp(32'd1000, 32'd3, 32'd333, 32'd1);

        repeat (40) @(negedge clk);
        check("sbEmpty", sbQ.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
